// File: rtl/wb_arbiter2_if.sv
`timescale 1ns/1ps
// wb_arbiter2_if
// Bundles every Wishbone signal around the two-master arbiter so that the
// arbiter and its environment connect through one port.
//
// Signals (names seen from the arbiter):
//   m0_*/m1_* : master request side (adr/dat/sel/we/cyc/stb in,
//               dat/ack/err out)
//   s_*       : shared slave side (muxed request out, dat/ack in)
//   gnt_o     : one-hot current grant, bit0 = m0, bit1 = m1
//
// Modports:
//   slave  : the arbiter itself, which is the target of the two masters
//   master : the environment (both initiators plus the downstream slave)
interface wb_arbiter2_if;
    logic [31:0] m0_adr_i;
    logic [31:0] m1_adr_i;
    logic [31:0] m0_dat_i;
    logic [31:0] m1_dat_i;
    logic [31:0] m0_dat_o;
    logic [31:0] m1_dat_o;
    logic [3:0]  m0_sel_i;
    logic [3:0]  m1_sel_i;
    logic        m0_we_i;
    logic        m0_cyc_i;
    logic        m0_stb_i;
    logic        m1_we_i;
    logic        m1_cyc_i;
    logic        m1_stb_i;
    logic        m0_ack_o;
    logic        m1_ack_o;
    logic        m0_err_o;
    logic        m1_err_o;
    logic [31:0] s_adr_o;
    logic [31:0] s_dat_o;
    logic [3:0]  s_sel_o;
    logic        s_we_o;
    logic        s_cyc_o;
    logic        s_stb_o;
    logic [31:0] s_dat_i;
    logic        s_ack_i;
    logic [1:0]  gnt_o;

    modport slave (
        input  m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i, m0_sel_i, m1_sel_i,
        input  m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i, m1_stb_i,
        input  s_dat_i, s_ack_i,
        output m0_dat_o, m1_dat_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
        output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, gnt_o
    );

    modport master (
        output m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i, m0_sel_i, m1_sel_i,
        output m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i, m1_stb_i,
        output s_dat_i, s_ack_i,
        input  m0_dat_o, m1_dat_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
        input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, gnt_o
    );
endinterface

// File: rtl/wb_arbiter2.sv
`timescale 1ns/1ps
// wb_arbiter2
// Two-master, one-slave Wishbone arbiter. Round-robin between m0 and m1 on
// simultaneous requests, grant held for the whole cyc, one idle cycle
// between grants, and an optional stall timeout that ends a hung cycle
// with a one-cycle bus error to the granted master.
//
// Ports:
//   clk   : system clock, all state on the rising edge
//   reset : synchronous, active-high
//   bus   : wb_arbiter2_if.slave, both master ports, the slave port and
//           the one-hot grant gnt_o
//
// Parameter:
//   TIMEOUT : stalled strobe cycles before a bus error; 0 disables it
module wb_arbiter2 #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         reset,
    wb_arbiter2_if.slave bus
);

    // With the timeout disabled the counter is kept as a single saturating bit.
    localparam int          CW      = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned LIMIT_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CW-1:0] LIMIT   = LIMIT_I[CW-1:0];
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS0 = 2'd1,
        BUS1 = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic          last, last_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          m0_err_q, m1_err_q;
    logic          m0_err_nxt, m1_err_nxt;
    logic          cur, cur_cyc, cur_stb;
    logic          stall, timeout_hit;

    // The timeout fires while the limit-th consecutive stall is in progress,
    // so cnt still holds the number of earlier stalled cycles.
    always_comb begin
        cur         = (state == BUS1);
        cur_cyc     = cur ? bus.m1_cyc_i : bus.m0_cyc_i;
        cur_stb     = cur ? bus.m1_stb_i : bus.m0_stb_i;
        stall       = (state != IDLE) && cur_stb && !bus.s_ack_i;
        timeout_hit = (TIMEOUT != 0) && stall && (cnt == LIMIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            last     <= 1'b1;
            cnt      <= '0;
            m0_err_q <= 1'b0;
            m1_err_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            cnt      <= cnt_nxt;
            m0_err_q <= m0_err_nxt;
            m1_err_q <= m1_err_nxt;
        end
    end

    // Leaving a BUS state always passes through IDLE, which is what gives
    // the single idle cycle between grants and clears the counter on entry.
    always_comb begin
        state_nxt  = state;
        last_nxt   = last;
        cnt_nxt    = cnt;
        m0_err_nxt = 1'b0;
        m1_err_nxt = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (bus.m0_cyc_i && bus.m1_cyc_i) begin
                    state_nxt = last ? BUS0 : BUS1;
                end else if (bus.m0_cyc_i) begin
                    state_nxt = BUS0;
                end else if (bus.m1_cyc_i) begin
                    state_nxt = BUS1;
                end
            end
            BUS0, BUS1: begin
                if (bus.s_ack_i) begin
                    cnt_nxt = '0;
                end else if (stall && (cnt != CNT_MAX)) begin
                    cnt_nxt = cnt + CW'(1);
                end
                if (!cur_cyc || timeout_hit) begin
                    state_nxt  = IDLE;
                    last_nxt   = cur;
                    cnt_nxt    = '0;
                    m0_err_nxt = timeout_hit && !cur;
                    m1_err_nxt = timeout_hit && cur;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request routing and ack forwarding are purely combinational so the
    // granted master sees the slave ack with no added latency.
    always_comb begin
        bus.s_adr_o  = bus.m0_adr_i;
        bus.s_dat_o  = bus.m0_dat_i;
        bus.s_sel_o  = bus.m0_sel_i;
        bus.s_we_o   = 1'b0;
        bus.s_cyc_o  = 1'b0;
        bus.s_stb_o  = 1'b0;
        bus.gnt_o    = 2'b00;
        bus.m0_ack_o = 1'b0;
        bus.m1_ack_o = 1'b0;
        case (state)
            BUS0: begin
                bus.s_we_o   = bus.m0_we_i;
                bus.s_cyc_o  = bus.m0_cyc_i;
                bus.s_stb_o  = bus.m0_stb_i;
                bus.gnt_o    = 2'b01;
                bus.m0_ack_o = bus.s_ack_i && bus.m0_stb_i;
            end
            BUS1: begin
                bus.s_adr_o  = bus.m1_adr_i;
                bus.s_dat_o  = bus.m1_dat_i;
                bus.s_sel_o  = bus.m1_sel_i;
                bus.s_we_o   = bus.m1_we_i;
                bus.s_cyc_o  = bus.m1_cyc_i;
                bus.s_stb_o  = bus.m1_stb_i;
                bus.gnt_o    = 2'b10;
                bus.m1_ack_o = bus.s_ack_i && bus.m1_stb_i;
            end
            default: ;
        endcase
    end

    assign bus.m0_err_o = m0_err_q;
    assign bus.m1_err_o = m1_err_q;
    assign bus.m0_dat_o = bus.s_dat_i;
    assign bus.m1_dat_o = bus.s_dat_i;

endmodule

// File: tb/tb_wb_arbiter2.sv
`timescale 1ns/1ps
// tb_wb_arbiter2
// Bench for wb_arbiter2. One instance with TIMEOUT=16 carries the table of
// per-cycle vectors, the round-robin sequence and the timeout sequence; a
// second instance with TIMEOUT=0 carries the long-stall sequence. Every
// cycle's expected outputs are queued when the inputs are driven and
// compared at the following falling edge.
module tb_wb_arbiter2;

    localparam logic [31:0] A0 = 32'h8000_0004;
    localparam logic [31:0] D0 = 32'h1111_1111;
    localparam logic [3:0]  S0 = 4'hF;
    localparam logic [31:0] A1 = 32'h4000_0010;
    localparam logic [31:0] D1 = 32'h2222_2222;
    localparam logic [3:0]  S1 = 4'h3;

    // One clock cycle of stimulus plus the outputs required in that cycle.
    // m0/m1/sctl are {cyc, stb, we}; acko/erro/gnt are {m1, m0}.
    typedef struct {
        string       name;
        logic        rst;
        logic [2:0]  m0;
        logic [2:0]  m1;
        logic        ack;
        logic [31:0] sdat;
        logic [1:0]  gnt;
        logic [2:0]  sctl;
        logic [1:0]  acko;
        logic [1:0]  erro;
    } vec_t;

    typedef struct packed {
        logic [1:0]  gnt;
        logic        s_cyc;
        logic        s_stb;
        logic        s_we;
        logic [31:0] s_adr;
        logic [31:0] s_dat;
        logic [3:0]  s_sel;
        logic [1:0]  ack;
        logic [1:0]  err;
        logic [31:0] m0_dat;
        logic [31:0] m1_dat;
    } obs_t;

    typedef struct {
        string name;
        bit    t0;
        obs_t  exp;
    } sb_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   passed = 0;
    sb_t  sbq[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    wb_arbiter2_if bus();
    wb_arbiter2_if bus_t0();

    wb_arbiter2 #(.TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    wb_arbiter2 #(.TIMEOUT(0)) dut_t0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_t0)
    );

    function automatic vec_t mk(input string n, input logic rst,
                                input logic [2:0] m0, input logic [2:0] m1,
                                input logic ack, input logic [31:0] sdat,
                                input logic [1:0] gnt, input logic [2:0] sctl,
                                input logic [1:0] acko, input logic [1:0] erro);
        vec_t v;
        v.name = n;  v.rst = rst;   v.m0 = m0;     v.m1 = m1;
        v.ack = ack; v.sdat = sdat; v.gnt = gnt;   v.sctl = sctl;
        v.acko = acko; v.erro = erro;
        return v;
    endfunction

    // The slave-side address/data/select follow m1 only while m1 holds the
    // grant; at every other time they show m0's values.
    function automatic obs_t expectFrom(input vec_t v);
        obs_t e;
        e.gnt    = v.gnt;
        e.s_cyc  = v.sctl[2];
        e.s_stb  = v.sctl[1];
        e.s_we   = v.sctl[0];
        e.s_adr  = (v.gnt == 2'b10) ? A1 : A0;
        e.s_dat  = (v.gnt == 2'b10) ? D1 : D0;
        e.s_sel  = (v.gnt == 2'b10) ? S1 : S0;
        e.ack    = v.acko;
        e.err    = v.erro;
        e.m0_dat = v.sdat;
        e.m1_dat = v.sdat;
        return e;
    endfunction

    function automatic obs_t sampleObs(input bit t0);
        obs_t o;
        if (t0) begin
            o.gnt = bus_t0.gnt_o;     o.s_cyc = bus_t0.s_cyc_o;
            o.s_stb = bus_t0.s_stb_o; o.s_we = bus_t0.s_we_o;
            o.s_adr = bus_t0.s_adr_o; o.s_dat = bus_t0.s_dat_o;
            o.s_sel = bus_t0.s_sel_o;
            o.ack = {bus_t0.m1_ack_o, bus_t0.m0_ack_o};
            o.err = {bus_t0.m1_err_o, bus_t0.m0_err_o};
            o.m0_dat = bus_t0.m0_dat_o; o.m1_dat = bus_t0.m1_dat_o;
        end else begin
            o.gnt = bus.gnt_o;     o.s_cyc = bus.s_cyc_o;
            o.s_stb = bus.s_stb_o; o.s_we = bus.s_we_o;
            o.s_adr = bus.s_adr_o; o.s_dat = bus.s_dat_o;
            o.s_sel = bus.s_sel_o;
            o.ack = {bus.m1_ack_o, bus.m0_ack_o};
            o.err = {bus.m1_err_o, bus.m0_err_o};
            o.m0_dat = bus.m0_dat_o; o.m1_dat = bus.m1_dat_o;
        end
        return o;
    endfunction

    task automatic applyStimulus(input vec_t v, input bit t0);
        sb_t s;
        reset = v.rst;
        if (t0) begin
            {bus_t0.m0_cyc_i, bus_t0.m0_stb_i, bus_t0.m0_we_i} = v.m0;
            {bus_t0.m1_cyc_i, bus_t0.m1_stb_i, bus_t0.m1_we_i} = v.m1;
            bus_t0.s_ack_i = v.ack;
            bus_t0.s_dat_i = v.sdat;
        end else begin
            {bus.m0_cyc_i, bus.m0_stb_i, bus.m0_we_i} = v.m0;
            {bus.m1_cyc_i, bus.m1_stb_i, bus.m1_we_i} = v.m1;
            bus.s_ack_i = v.ack;
            bus.s_dat_i = v.sdat;
        end
        s.name = v.name;
        s.t0   = t0;
        s.exp  = expectFrom(v);
        sbq.push_back(s);
    endtask

    task automatic checkOutput();
        sb_t  s;
        obs_t a;
        total++;
        if (sbq.size() == 0) begin
            $display("[TB] FAIL scoreboard_underflow: got empty queue, expected one entry");
            return;
        end
        s = sbq.pop_front();
        a = sampleObs(s.t0);
        if (a !== s.exp) begin
            $display("[TB] FAIL %s: got gnt=%b cyc/stb/we=%b%b%b adr=%h dat=%h sel=%h ack=%b err=%b rd=%h/%h, expected gnt=%b cyc/stb/we=%b%b%b adr=%h dat=%h sel=%h ack=%b err=%b rd=%h/%h",
                     s.name, a.gnt, a.s_cyc, a.s_stb, a.s_we, a.s_adr, a.s_dat, a.s_sel,
                     a.ack, a.err, a.m0_dat, a.m1_dat,
                     s.exp.gnt, s.exp.s_cyc, s.exp.s_stb, s.exp.s_we, s.exp.s_adr,
                     s.exp.s_dat, s.exp.s_sel, s.exp.ack, s.exp.err, s.exp.m0_dat,
                     s.exp.m1_dat);
        end else begin
            passed++;
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are judged at the
    // falling edge of the same cycle.
    task automatic step(input vec_t v, input bit t0);
        @(posedge clk);
        #1;
        applyStimulus(v, t0);
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        vec_t v;
        bus.m0_adr_i = A0; bus.m0_dat_i = D0; bus.m0_sel_i = S0;
        bus.m1_adr_i = A1; bus.m1_dat_i = D1; bus.m1_sel_i = S1;
        {bus.m0_cyc_i, bus.m0_stb_i, bus.m0_we_i} = 3'b000;
        {bus.m1_cyc_i, bus.m1_stb_i, bus.m1_we_i} = 3'b000;
        bus.s_ack_i = 1'b0; bus.s_dat_i = '0;
        bus_t0.m0_adr_i = A0; bus_t0.m0_dat_i = D0; bus_t0.m0_sel_i = S0;
        bus_t0.m1_adr_i = A1; bus_t0.m1_dat_i = D1; bus_t0.m1_sel_i = S1;
        {bus_t0.m0_cyc_i, bus_t0.m0_stb_i, bus_t0.m0_we_i} = 3'b000;
        {bus_t0.m1_cyc_i, bus_t0.m1_stb_i, bus_t0.m1_we_i} = 3'b000;
        bus_t0.s_ack_i = 1'b0; bus_t0.s_dat_i = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);

        //                 name                 rst m0      m1      ack sdat           gnt    sctl    acko   erro
        tbl.push_back(mk("rst_state",           1, 3'b000, 3'b000, 0, 32'h0,         2'b00, 3'b000, 2'b00, 2'b00));
        tbl.push_back(mk("m0_rd_req",           0, 3'b110, 3'b000, 0, 32'h0,         2'b00, 3'b000, 2'b00, 2'b00));
        tbl.push_back(mk("m0_rd_grant",         0, 3'b110, 3'b000, 0, 32'h0,         2'b01, 3'b110, 2'b00, 2'b00));
        tbl.push_back(mk("m0_rd_ack",           0, 3'b110, 3'b000, 1, 32'hDEADBEEF,  2'b01, 3'b110, 2'b01, 2'b00));
        tbl.push_back(mk("ack_on_cyc_fall",     0, 3'b010, 3'b000, 1, 32'h0,         2'b01, 3'b010, 2'b01, 2'b00));
        tbl.push_back(mk("idle_after_m0",       0, 3'b000, 3'b000, 0, 32'h0,         2'b00, 3'b000, 2'b00, 2'b00));
        tbl.push_back(mk("m1_wr_req",           0, 3'b000, 3'b111, 0, 32'h0,         2'b00, 3'b000, 2'b00, 2'b00));
        tbl.push_back(mk("m1_wr_grant",         0, 3'b110, 3'b111, 0, 32'h0,         2'b10, 3'b111, 2'b00, 2'b00));
        tbl.push_back(mk("m1_ack_m0_pending",   0, 3'b110, 3'b111, 1, 32'h0,         2'b10, 3'b111, 2'b10, 2'b00));
        tbl.push_back(mk("m1_release",          0, 3'b110, 3'b000, 0, 32'h0,         2'b10, 3'b000, 2'b00, 2'b00));
        tbl.push_back(mk("gap_before_m0",       0, 3'b110, 3'b000, 0, 32'h0,         2'b00, 3'b000, 2'b00, 2'b00));
        tbl.push_back(mk("burst_grant",         0, 3'b110, 3'b110, 0, 32'h0,         2'b01, 3'b110, 2'b00, 2'b00));
        tbl.push_back(mk("burst_ack1",          0, 3'b110, 3'b110, 1, 32'h0,         2'b01, 3'b110, 2'b01, 2'b00));
        tbl.push_back(mk("burst_ack2",          0, 3'b110, 3'b110, 1, 32'h0,         2'b01, 3'b110, 2'b01, 2'b00));
        tbl.push_back(mk("burst_ack3",          0, 3'b110, 3'b110, 1, 32'h0,         2'b01, 3'b110, 2'b01, 2'b00));
        tbl.push_back(mk("burst_release",       0, 3'b000, 3'b110, 0, 32'h0,         2'b01, 3'b000, 2'b00, 2'b00));
        tbl.push_back(mk("burst_gap",           0, 3'b000, 3'b110, 0, 32'h0,         2'b00, 3'b000, 2'b00, 2'b00));
        tbl.push_back(mk("m1_grant_2_after",    0, 3'b000, 3'b110, 0, 32'h0,         2'b10, 3'b110, 2'b00, 2'b00));
        tbl.push_back(mk("m1_ack_b",            0, 3'b000, 3'b110, 1, 32'h0,         2'b10, 3'b110, 2'b10, 2'b00));
        tbl.push_back(mk("m1_release_b",        0, 3'b000, 3'b000, 0, 32'h0,         2'b10, 3'b000, 2'b00, 2'b00));
        tbl.push_back(mk("tie_idle",            0, 3'b110, 3'b110, 0, 32'h0,         2'b00, 3'b000, 2'b00, 2'b00));
        tbl.push_back(mk("tie_to_m0",           0, 3'b110, 3'b110, 0, 32'h0,         2'b01, 3'b110, 2'b00, 2'b00));
        tbl.push_back(mk("tie_m0_ack",          0, 3'b110, 3'b110, 1, 32'h0,         2'b01, 3'b110, 2'b01, 2'b00));
        tbl.push_back(mk("tie_m0_release",      0, 3'b000, 3'b110, 0, 32'h0,         2'b01, 3'b000, 2'b00, 2'b00));
        tbl.push_back(mk("m0_only_idle",        0, 3'b110, 3'b000, 0, 32'h0,         2'b00, 3'b000, 2'b00, 2'b00));
        tbl.push_back(mk("m0_stall1",           0, 3'b110, 3'b110, 0, 32'h0,         2'b01, 3'b110, 2'b00, 2'b00));
        tbl.push_back(mk("m0_stall2",           0, 3'b110, 3'b110, 0, 32'h0,         2'b01, 3'b110, 2'b00, 2'b00));
        tbl.push_back(mk("reset_mid_xfer",      1, 3'b110, 3'b110, 0, 32'h0,         2'b01, 3'b110, 2'b00, 2'b00));
        tbl.push_back(mk("post_reset_idle",     0, 3'b110, 3'b110, 0, 32'h0,         2'b00, 3'b000, 2'b00, 2'b00));
        tbl.push_back(mk("post_reset_m0_first", 0, 3'b110, 3'b110, 0, 32'h0,         2'b01, 3'b110, 2'b00, 2'b00));
        tbl.push_back(mk("post_reset_ack",      0, 3'b110, 3'b110, 1, 32'h0,         2'b01, 3'b110, 2'b01, 2'b00));
        tbl.push_back(mk("post_reset_release",  0, 3'b000, 3'b110, 0, 32'h0,         2'b01, 3'b000, 2'b00, 2'b00));
        tbl.push_back(mk("final_idle",          0, 3'b000, 3'b000, 0, 32'h0,         2'b00, 3'b000, 2'b00, 2'b00));

        // Rows without explicit read data get a per-row background value so a
        // stuck or miswired read path is visible on every row.
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            if (v.sdat == 32'h0) v.sdat = 32'h5A00_0000 + i;
            step(v, 1'b0);
        end

        $display("[TB] round-robin with both masters always requesting");
        step(mk("rr_reset", 1, 3'b000, 3'b000, 0, 32'h77, 2'b00, 3'b000, 2'b00, 2'b00), 1'b0);
        for (int r = 0; r < 4; r++) begin
            logic [1:0] gv;
            gv = (r % 2 == 1) ? 2'b10 : 2'b01;
            step(mk($sformatf("rr%0d_idle", r), 0, 3'b110, 3'b110, 0, 32'hC0DE_0000 + r,
                    2'b00, 3'b000, 2'b00, 2'b00), 1'b0);
            step(mk($sformatf("rr%0d_grant", r), 0, 3'b110, 3'b110, 1, 32'hC0DE_0100 + r,
                    gv, 3'b110, gv, 2'b00), 1'b0);
            step(mk($sformatf("rr%0d_release", r), 0,
                    (r % 2 == 1) ? 3'b110 : 3'b000, (r % 2 == 1) ? 3'b000 : 3'b110,
                    0, 32'hC0DE_0200 + r, gv, 3'b000, 2'b00, 2'b00), 1'b0);
        end
        step(mk("rr_done", 0, 3'b000, 3'b000, 0, 32'h88, 2'b00, 3'b000, 2'b00, 2'b00), 1'b0);

        $display("[TB] stall timeout on m1 with TIMEOUT=16");
        step(mk("to_reset", 1, 3'b000, 3'b000, 0, 32'h99, 2'b00, 3'b000, 2'b00, 2'b00), 1'b0);
        step(mk("to_req", 0, 3'b000, 3'b110, 0, 32'h9A, 2'b00, 3'b000, 2'b00, 2'b00), 1'b0);
        for (int k = 1; k <= 16; k++) begin
            step(mk($sformatf("to_stall%0d", k), 0, 3'b000, 3'b110, 0, 32'hB000_0000 + k,
                    2'b10, 3'b110, 2'b00, 2'b00), 1'b0);
        end
        step(mk("to_err_pulse", 0, 3'b000, 3'b110, 0, 32'h9B, 2'b00, 3'b000, 2'b00, 2'b10), 1'b0);
        step(mk("to_rearbitrate", 0, 3'b000, 3'b110, 0, 32'h9C, 2'b10, 3'b110, 2'b00, 2'b00), 1'b0);
        step(mk("to_release", 0, 3'b000, 3'b000, 0, 32'h9D, 2'b10, 3'b000, 2'b00, 2'b00), 1'b0);
        step(mk("to_idle", 0, 3'b000, 3'b000, 0, 32'h9E, 2'b00, 3'b000, 2'b00, 2'b00), 1'b0);

        $display("[TB] 5000-cycle stall with TIMEOUT=0");
        step(mk("t0_reset", 1, 3'b000, 3'b000, 0, 32'hA1, 2'b00, 3'b000, 2'b00, 2'b00), 1'b1);
        step(mk("t0_req", 0, 3'b110, 3'b000, 0, 32'hA2, 2'b00, 3'b000, 2'b00, 2'b00), 1'b1);
        for (int k = 0; k < 5000; k++) begin
            step(mk("t0_stall", 0, 3'b110, 3'b000, 0, 32'hE000_0000 + k,
                    2'b01, 3'b110, 2'b00, 2'b00), 1'b1);
        end
        step(mk("t0_late_ack", 0, 3'b110, 3'b000, 1, 32'hFEED_F00D, 2'b01, 3'b110, 2'b01, 2'b00), 1'b1);
        step(mk("t0_release", 0, 3'b000, 3'b000, 0, 32'hA3, 2'b01, 3'b000, 2'b00, 2'b00), 1'b1);
        step(mk("t0_idle", 0, 3'b000, 3'b000, 0, 32'hA4, 2'b00, 3'b000, 2'b00, 2'b00), 1'b1);

        total++;
        if (sbq.size() != 0) begin
            $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", sbq.size());
        end else begin
            passed++;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/wb_arbiter2.md
WB_ARBITER2 -- requirements
Module: wb_arbiter2

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024: stalled-strobe cycles before bus error; 0 disables timeout.
REQ-002 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports m0_adr_i, m1_adr_i  input  32  master byte addresses.
REQ-005 SHALL have ports m0_dat_i, m1_dat_i  input  32  master write data.
REQ-006 SHALL have ports m0_dat_o, m1_dat_o  output  32  read data, both driven from s_dat_i.
REQ-007 SHALL have ports m0_sel_i, m1_sel_i  input  4  byte selects.
REQ-008 SHALL have ports m0_we_i/m0_cyc_i/m0_stb_i and m1_we_i/m1_cyc_i/m1_stb_i  input  1 each  Wishbone controls.
REQ-009 SHALL have ports m0_ack_o, m1_ack_o, m0_err_o, m1_err_o  output  1 each  cycle termination.
REQ-010 SHALL have ports s_adr_o 32, s_dat_o 32, s_sel_o 4, s_we_o/s_cyc_o/s_stb_o 1  output  muxed slave request.
REQ-011 SHALL have ports s_dat_i  input  32 and s_ack_i  input  1  slave response.
REQ-012 SHALL have port gnt_o  output  2  one-hot current grant (bit0=m0, bit1=m1), 00 when idle.

Function
REQ-013 SHALL implement states IDLE, BUS0, BUS1 plus a 1-bit last-served pointer and a timeout counter of width clog2(TIMEOUT+1).
REQ-014 In IDLE, SHALL sample m0_cyc_i/m1_cyc_i: only one high -> that master's BUS state next edge; both high -> master other than last-served; neither -> stay IDLE.
REQ-015 In IDLE, SHALL drive s_cyc_o=s_stb_o=s_we_o=0, gnt_o=00, both acks and errs 0; s_adr_o/s_dat_o/s_sel_o = m0 values (don't-care).
REQ-016 In BUSn, SHALL combinationally route mn adr/dat/sel/we/cyc/stb to s_* and set gnt_o bit n.
REQ-017 In BUSn, SHALL drive mn_ack_o = s_ack_i & mn_stb_i combinationally (zero added latency); the other master's ack SHALL be 0.
REQ-018 Grant SHALL persist while mn_cyc_i high (multi-transfer cycles allowed); on first edge with mn_cyc_i low SHALL return to IDLE and set last-served=n.
REQ-019 A returning grant SHALL cost exactly one IDLE cycle (s_cyc_o low) before the next grant.
REQ-020 An ack coincident with mn_cyc_i falling SHALL still be forwarded in that cycle.
REQ-021 Timeout counter SHALL clear on BUS entry and on any s_ack_i; SHALL increment each BUS cycle with s_stb_o=1 and s_ack_i=0.
REQ-022 When TIMEOUT!=0 and the TIMEOUT-th consecutive stalled cycle occurs, next edge SHALL: go IDLE, set last-served=n, pulse mn_err_o high for exactly one cycle (registered), clear counter.
REQ-023 While mn_err_o is high, s_cyc_o SHALL be 0; a master still holding cyc is re-arbitrated per REQ-014.
REQ-024 Counter SHALL saturate, never wrap; TIMEOUT=0 SHALL never assert err.
REQ-025 Strobes from the non-granted master SHALL be ignored, produce no ack/err, and remain pending.

Reset
REQ-026 On reset high at an edge: state IDLE, last-served=1 (m0 wins first tie), counter 0, err outputs 0; hence all s_* controls, acks, gnt_o = 0 the following cycle.
REQ-027 Reset asserted mid-transfer SHALL abandon the transfer without ack or err; no state survives reset.

Verification
REQ-028 m0 read 0x80000004, slave acks cycle 2 with 0xDEADBEEF -> s_cyc_o high from cycle 1, m0_ack_o=1 and m0_dat_o=0xDEADBEEF in cycle 2, gnt_o=01.
REQ-029 After reset both masters request continuously, each single transfer -> grants m0,m1,m0,m1 with one IDLE cycle between each.
REQ-030 m0 holds cyc for 3 acked transfers while m1 requests -> m1 never acked during them; gnt_o=10 exactly two cycles after m0_cyc_i falls.
REQ-031 TIMEOUT=16, m1 strobes, slave never acks -> m1_err_o single-cycle pulse after 16th stalled cycle, s_cyc_o low that cycle, no ack.
REQ-032 Reset pulsed during m0 stalled transfer -> next cycle gnt_o=00, s_cyc_o=0, no ack/err; subsequent simultaneous request granted to m0.
REQ-033 TIMEOUT=0, slave stalls 5000 cycles then acks -> no err, ack forwarded, counter saturates without wrap.
